sched_write_engine: RTL



---
 rtl/sched_write_engine.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/sched_write_engine.sv
// sched_write_engine: delayed-write executor.
// Each accepted request writes `q` exactly req_delay edges after acceptance.
// Delay 0 writes at the accept edge; delay d >= 1 parks the request in a slot
// that counts down and fires at edge N+d. When several writes land on one
// edge, the most recently accepted request wins.
// Optional feature macro: SWE_CANCEL_EN adds the `flush` input, which
// cancels every pending slot at the edge where it is sampled high.
module sched_write_engine #(
    parameter int DATA_W = 4,
    parameter int DLY_W  = 3,
    parameter int DEPTH  = 4,
    parameter int INIT   = 4,
    localparam int PW    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
`ifdef SWE_CANCEL_EN
    input  logic              flush,
`endif
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [DATA_W-1:0] req_data,
    input  logic [DLY_W-1:0]  req_delay,
    output logic [DATA_W-1:0] q,
    output logic              upd,
    output logic [PW-1:0]     pending
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [DATA_W-1:0] INIT_Q = DATA_W'(INIT);

    // Slot storage. Only the valid bits carry meaning after reset.
    logic [DEPTH-1:0]  slot_vld;
    logic [DATA_W-1:0] slot_data [DEPTH];
    logic [DLY_W-1:0]  slot_cnt  [DEPTH];
    logic [DLY_W-1:0]  slot_age  [DEPTH];

    logic              flush_now;
    logic              accept;
    logic              imm;
    logic              load;
    logic [DEPTH-1:0]  expire;
    logic              have_win;
    logic [DLY_W-1:0]  best_age;
    logic [DATA_W-1:0] win_data;
    logic [IW-1:0]     free_idx;
    logic [PW-1:0]     fire_cnt;
    logic              q_wr;
    logic [DATA_W-1:0] q_nxt;
    logic [PW-1:0]     pend_nxt;

`ifdef SWE_CANCEL_EN
    assign flush_now = flush;
`else
    assign flush_now = 1'b0;
`endif

    // Ready depends on registered occupancy only, never on req_valid.
    assign req_ready = (pending != PW'(DEPTH));
    assign accept    = req_valid && req_ready;
    assign imm       = accept && (req_delay == '0);
    assign load      = accept && (req_delay != '0);

    // Pick expiring slots, the newest expiring write, and the lowest free slot.
    always_comb begin
        // NOTE: every signal written here gets a default first so no latch is inferred.
        expire   = '0;
        have_win = 1'b0;
        best_age = '1;
        win_data = '0;
        free_idx = '0;
        fire_cnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            expire[i] = slot_vld[i] && (slot_cnt[i] == DLY_W'(1)) && !flush_now;
            if (expire[i]) begin
                fire_cnt = fire_cnt + PW'(1);
                // Smaller age means accepted later, so it overrides older ones.
                if (!have_win || (slot_age[i] < best_age)) begin
                    have_win = 1'b1;
                    best_age = slot_age[i];
                    win_data = slot_data[i];
                end
            end
        end
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!slot_vld[i]) free_idx = IW'(i);
        end
    end

    // Resolve the value written to q this edge and the next occupancy count.
    always_comb begin
        q_wr  = imm || have_win;
        q_nxt = q;
        if (imm)           q_nxt = req_data;
        else if (have_win) q_nxt = win_data;
        if (flush_now) pend_nxt = PW'(load);
        else           pend_nxt = pending + PW'(load) - fire_cnt;
    end

    // Slot occupancy: cleared by reset, flush or firing; set by a load.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers
        // update from the same pre-edge values.
        if (rst) begin
            slot_vld <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (flush_now || expire[i]) slot_vld[i] <= 1'b0;
                if (load && (free_idx == IW'(i))) slot_vld[i] <= 1'b1;
            end
        end
    end

    // Slot payload, countdown and age.
    always_ff @(posedge clk) begin
        // NOTE: the payload array has no reset; a slot is ignored until its
        // valid bit is set, and a load rewrites all fields.
        for (int i = 0; i < DEPTH; i++) begin
            if (load && (free_idx == IW'(i))) begin
                slot_data[i] <= req_data;
                slot_cnt[i]  <= req_delay;
                slot_age[i]  <= '0;
            end else if (slot_vld[i]) begin
                slot_cnt[i] <= slot_cnt[i] - DLY_W'(1);
                if (slot_age[i] != '1) slot_age[i] <= slot_age[i] + DLY_W'(1);
            end
        end
    end

    // Target register, update pulse and occupancy count.
    always_ff @(posedge clk) begin
        if (rst) begin
            q       <= INIT_Q;
            upd     <= 1'b0;
            pending <= '0;
        end else begin
            q       <= q_nxt;
            upd     <= q_wr;
            pending <= pend_nxt;
        end
    end

endmodule
